// File: rtl/aes_spi_slave_frame.sv
// aes_spi_slave_frame: SPI mode-0 slave that frames AES commands in and streams status+result back out
// Ports: clk, reset (async, active-low); sclk, cs, mosi, miso: SPI slave pins;
//        core_valid/core_ready, core_text, core_key_size, core_key: command to the AES core;
//        res_valid/res_ready, res_data: result from the core; busy, done, frame_err: status.
module aes_spi_slave_frame #(
   parameter int FRAME_BITS  = 392,
   parameter int SYNC_STAGES = 2
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         sclk,
   input  logic         cs,
   input  logic         mosi,
   output logic         miso,
   output logic         core_valid,
   input  logic         core_ready,
   output logic [127:0] core_text,
   output logic [7:0]   core_key_size,
   output logic [255:0] core_key,
   input  logic         res_valid,
   input  logic [127:0] res_data,
   output logic         res_ready,
   output logic         busy,
   output logic         done,
   output logic         frame_err
);
   typedef enum logic [1:0] {IDLE, HOLD, BUSY} state_t;
   localparam logic [8:0] FULL = 9'(FRAME_BITS);
   state_t state, state_n;
   logic [SYNC_STAGES-1:0] sclk_r, cs_r, mosi_r;
   logic sclk_q, cs_q, end_p;
   logic sclk_s, cs_s, mosi_s, sclk_rise, sclk_fall, cs_fall, cs_rise;
   logic [FRAME_BITS-1:0] rx_shift, tx_shift;
   logic [8:0] bit_cnt;
   logic [7:0] status, key_size;
   logic [127:0] result;
   logic len_ok, ks_ok, frame_ok;
   assign sclk_s    = sclk_r[SYNC_STAGES-1];
   assign cs_s      = cs_r[SYNC_STAGES-1];
   assign mosi_s    = mosi_r[SYNC_STAGES-1];
   assign sclk_rise = ~cs_s & sclk_s & ~sclk_q;
   assign sclk_fall = ~cs_s & ~sclk_s & sclk_q;
   assign cs_fall   = cs_q & ~cs_s;
   assign cs_rise   = ~cs_q & cs_s;
   assign key_size  = rx_shift[FRAME_BITS-129 -: 8];
   assign ks_ok     = key_size == 8'd16 || key_size == 8'd24 || key_size == 8'd32;
   assign len_ok    = bit_cnt == FULL;
   assign frame_ok  = end_p && len_ok && ks_ok && state == IDLE;
   assign miso      = ~cs_s & tx_shift[FRAME_BITS-1];
   // cs synchroniser resets to the deselected level so reset release never fakes a frame end
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sclk_r <= '0;
         mosi_r <= '0;
         cs_r   <= '1;
         sclk_q <= 1'b0;
         cs_q   <= 1'b1;
         end_p  <= 1'b0;
      end else begin
         sclk_r <= {sclk_r[SYNC_STAGES-2:0], sclk};
         mosi_r <= {mosi_r[SYNC_STAGES-2:0], mosi};
         cs_r   <= {cs_r[SYNC_STAGES-2:0], cs};
         sclk_q <= sclk_s;
         cs_q   <= cs_s;
         end_p  <= cs_rise;
      end
   end
   // tx_shift reloads while deselected, so a result captured mid-frame waits for the next frame
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rx_shift <= '0;
         tx_shift <= '0;
         bit_cnt  <= '0;
      end else begin
         if (cs_fall)
            bit_cnt <= '0;
         else if (sclk_rise) begin
            rx_shift <= {rx_shift[FRAME_BITS-2:0], mosi_s};
            bit_cnt  <= bit_cnt + 9'(bit_cnt != '1);
         end
         if (cs_s)
            tx_shift <= {status, result, {(FRAME_BITS-136){1'b0}}};
         else if (sclk_fall)
            tx_shift <= {tx_shift[FRAME_BITS-2:0], 1'b0};
      end
   end
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         state <= IDLE;
      else
         state <= state_n;
   end
   always_comb begin
      core_valid = state == HOLD;
      res_ready  = state == BUSY;
      busy       = state != IDLE;
      state_n    = state == IDLE ? (frame_ok ? HOLD : IDLE) :
                   state == HOLD ? (core_ready ? BUSY : HOLD) :
                                   (res_valid ? IDLE : BUSY);
   end
   // errors outrank a same-cycle result capture; the capture itself still completes
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         core_text     <= '0;
         core_key_size <= '0;
         core_key      <= '0;
         status        <= '0;
         result        <= '0;
         done          <= 1'b0;
         frame_err     <= 1'b0;
      end else begin
         if (frame_ok) begin
            core_text     <= rx_shift[FRAME_BITS-1 -: 128];
            core_key_size <= key_size;
            core_key      <= rx_shift[255:0];
         end
         if (res_valid && res_ready)
            result <= res_data;
         status    <= end_p && !len_ok      ? 8'hE1 :
                      end_p && state != IDLE ? 8'hE3 :
                      end_p && !ks_ok        ? 8'hE2 :
                      frame_ok               ? 8'h00 :
                      res_valid && res_ready ? 8'h01 : status;
         done      <= res_valid && res_ready;
         frame_err <= end_p && !frame_ok;
      end
   end
endmodule

// File: tb/tb_aes_spi_slave_frame.sv
// tb_aes_spi_slave_frame: directed frame vectors and handshake sequences for aes_spi_slave_frame
module tb_aes_spi_slave_frame;
   logic clk = 1'b0, reset, sclk, cs, mosi, miso;
   logic core_valid, core_ready, res_valid, res_ready, busy, done, frame_err;
   logic [127:0] core_text, res_data;
   logic [7:0]   core_key_size;
   logic [255:0] core_key;
   int n_vec = 0, n_bad = 0;
   always #5 clk = ~clk;
   aes_spi_slave_frame dut (
      .clk(clk), .reset(reset), .sclk(sclk), .cs(cs), .mosi(mosi), .miso(miso),
      .core_valid(core_valid), .core_ready(core_ready), .core_text(core_text),
      .core_key_size(core_key_size), .core_key(core_key), .res_valid(res_valid),
      .res_data(res_data), .res_ready(res_ready), .busy(busy), .done(done), .frame_err(frame_err)
   );
   typedef struct {
      logic [391:0] frame;
      int           n;
      logic [127:0] res;
      bit           acc;
      logic [7:0]   st;
      logic [127:0] rres;
   } vec_t;
   vec_t vec [6];
   localparam logic [127:0] PT   = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] R128 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
   localparam logic [127:0] R192 = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
   localparam logic [127:0] R256 = 128'h8ea2b7ca516745bfeafc49904b496089;
   localparam logic [255:0] K128 = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
   localparam logic [255:0] K192 = {192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0};
   localparam logic [255:0] K256 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
   function automatic logic [391:0] mk(input logic [127:0] t, input logic [7:0] ks, input logic [255:0] k);
      return {t, ks, k};
   endfunction
   task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask
   // one SPI mode-0 transfer, 4 clk per sclk phase; r collects miso MSB first
   task automatic xfer(input logic [399:0] w, input int n, output logic [399:0] r);
      r = '0;
      @(negedge clk);
      cs = 1'b0;
      for (int i = n - 1; i >= 0; i--) begin
         mosi = w[i];
         repeat (4) @(negedge clk);
         sclk = 1'b1;
         r = {r[398:0], miso};
         repeat (4) @(negedge clk);
         sclk = 1'b0;
      end
      repeat (4) @(negedge clk);
      cs   = 1'b1;
      mosi = 1'b0;
   endtask
   // watches 20 cycles after cs rise: frame_err seen, final core_valid, cycle index of core_valid rise
   task automatic wait_eval(output bit v, output bit e, output int lat);
      bit v0;
      v0 = core_valid;
      e = 1'b0;
      lat = -1;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         if (frame_err) e = 1'b1;
         if (core_valid && !v0 && lat < 0) lat = k;
      end
      v = core_valid;
   endtask
   task automatic run_core(input logic [127:0] res);
      chk("busy_hold", busy, 1);
      @(negedge clk);
      core_ready = 1'b1;
      @(negedge clk);
      core_ready = 1'b0;
      chk("valid_drop", core_valid, 0);
      chk("res_ready", res_ready, 1);
      chk("busy_run", busy, 1);
      repeat (3) @(negedge clk);
      res_valid = 1'b1;
      res_data  = res;
      @(negedge clk);
      res_valid = 1'b0;
      chk("done", done, 1);
      chk("busy_end", busy, 0);
      chk("res_ready_end", res_ready, 0);
      @(negedge clk);
      chk("done_pulse", done, 0);
   endtask
   function automatic logic [399:0] fit(input logic [391:0] f, input int n);
      logic [399:0] w;
      w = {8'h0, f};
      return n >= 392 ? w << (n - 392) : w >> (392 - n);
   endfunction
   initial begin
      logic [399:0] r;
      logic [7:0]   pst;
      logic [127:0] pres;
      bit v, e;
      int lat;
      vec[0] = '{mk(PT, 8'd16, K128), 392, R128, 1'b1, 8'h01, R128};
      vec[1] = '{mk(PT, 8'd24, K192), 392, R192, 1'b1, 8'h01, R192};
      vec[2] = '{mk(PT, 8'd20, K128), 392, '0, 1'b0, 8'hE2, R192};
      vec[3] = '{mk(PT, 8'd16, K128), 391, '0, 1'b0, 8'hE1, R192};
      vec[4] = '{mk(PT, 8'd16, K128), 400, '0, 1'b0, 8'hE1, R192};
      vec[5] = '{mk(PT, 8'd32, K256), 392, R256, 1'b1, 8'h01, R256};
      reset = 1'b0; cs = 1'b1; sclk = 1'b0; mosi = 1'b0;
      core_ready = 1'b0; res_valid = 1'b0; res_data = '0;
      repeat (3) @(negedge clk);
      chk("rst_core_valid", core_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_res_ready", res_ready, 0);
      chk("rst_miso", miso, 0);
      chk("rst_flags", {done, frame_err}, 0);
      chk("rst_core_text", core_text, 0);
      reset = 1'b1;
      repeat (5) @(negedge clk);
      pst = 8'h00;
      pres = '0;
      for (int i = 0; i < 6; i++) begin
         xfer(fit(vec[i].frame, vec[i].n), vec[i].n, r);
         chk("rb_status", 256'(r[vec[i].n-1 -: 8]), 256'(pst));
         chk("rb_result", 256'(r[vec[i].n-9 -: 128]), 256'(pres));
         wait_eval(v, e, lat);
         chk("frame_err", e, !vec[i].acc);
         chk("core_valid", v, vec[i].acc);
         if (vec[i].acc) begin
            chk("latency", lat, 3);
            chk("core_text", core_text, vec[i].frame[391:264]);
            chk("core_key_size", core_key_size, vec[i].frame[263:256]);
            chk("core_key", core_key, vec[i].frame[255:0]);
            run_core(vec[i].res);
         end
         pst = vec[i].st;
         pres = vec[i].rres;
      end
      // overrun: second frame arrives while the first sits in HOLD
      xfer(fit(vec[5].frame, 392), 392, r);
      chk("ovr_rb_status", r[391:384], 8'h01);
      chk("ovr_rb_result", r[383:256], R256);
      wait_eval(v, e, lat);
      chk("ovr_accept", {v, e}, 2'b10);
      xfer(fit(vec[0].frame, 392), 392, r);
      chk("ovr_consumed_status", r[391:384], 8'h00);
      chk("ovr_consumed_result", r[383:256], R256);
      wait_eval(v, e, lat);
      chk("ovr_err", e, 1);
      chk("ovr_still_valid", v, 1);
      chk("ovr_text_kept", core_text, PT);
      chk("ovr_key_kept", core_key, K256);
      chk("ovr_ks_kept", core_key_size, 8'd32);
      run_core(R256);
      xfer(fit(mk('0, 8'd0, '0), 392), 392, r);
      chk("ovr_after_status", r[391:384], 8'h01);
      chk("ovr_after_result", r[383:256], R256);
      wait_eval(v, e, lat);
      chk("ks0_err", e, 1);
      // reset in the middle of a frame while a command is held
      xfer(fit(vec[0].frame, 392), 392, r);
      chk("pre_rst_status", r[391:384], 8'hE2);
      wait_eval(v, e, lat);
      chk("pre_rst_valid", v, 1);
      @(negedge clk);
      cs = 1'b0;
      for (int i = 0; i < 200; i++) begin
         mosi = i[0];
         repeat (4) @(negedge clk);
         sclk = 1'b1;
         repeat (4) @(negedge clk);
         sclk = 1'b0;
      end
      reset = 1'b0;
      cs = 1'b1;
      mosi = 1'b0;
      #1;
      chk("mid_rst_valid", core_valid, 0);
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_text", core_text, 0);
      chk("mid_rst_key", core_key, 0);
      chk("mid_rst_miso", miso, 0);
      repeat (2) @(negedge clk);
      reset = 1'b1;
      repeat (5) @(negedge clk);
      xfer(fit(vec[0].frame, 392), 392, r);
      chk("post_rst_status", r[391:384], 8'h00);
      chk("post_rst_result", r[383:256], 0);
      wait_eval(v, e, lat);
      chk("post_rst_accept", {v, e}, 2'b10);
      chk("post_rst_latency", lat, 3);
      chk("post_rst_text", core_text, PT);
      chk("post_rst_key", core_key, K128);
      run_core(R128);
      xfer(fit(mk('0, 8'd0, '0), 392), 392, r);
      chk("final_status", r[391:384], 8'h01);
      chk("final_result", r[383:256], R128);
      wait_eval(v, e, lat);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule
